// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches the PS/2 pins, deframes
// 11-bit frames, and folds E0/F0 prefixes into flags on a single key event.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scan_code,
    output logic       key_released,
    output logic       key_extended,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [7:0]    scan_q, scan_d;
    logic          rel_q, rel_d, extd_q, extd_d;
    logic          valid_q, valid_d, err_q, err_d;

    logic clk_s, dat_s, fall;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    // One-cycle strobe on the filtered clock's 1->0 transition
    assign fall  = filt_prev_q & ~filt_q;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        scan_d    = scan_q;
        rel_d     = rel_q;
        extd_d    = extd_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        to_cnt_d  = (state_q == S_IDLE || fall) ? '0 : to_cnt_q + TW'(1);

        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (dat_s && (^{shift_q, par_q})) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            scan_d  = shift_q;
                            rel_d   = brk_q;
                            extd_d  = ext_q;
                            valid_d = 1'b1;
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
                        end
                    end else begin
                        err_d = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                end
            endcase
        end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
            // Stalled partial frame: drop it and any pending prefixes
            state_d = S_IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            scan_q      <= 8'h00;
            rel_q       <= 1'b0;
            extd_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q  <= {dat_sync_q[0], PS2_DAT};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            scan_q      <= scan_d;
            rel_q       <= rel_d;
            extd_q      <= extd_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    assign scan_code    = scan_q;
    assign key_released = rel_q;
    assign key_extended = extd_q;
    assign key_valid    = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: drives PS/2 frames on the pins and
// compares pulses and held outputs against a frame-level reference model.
module tb_ps2_keyboard_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 250;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] scan_code;
    logic       key_released;
    logic       key_extended;
    logic       key_valid;
    logic       frame_err;

    ps2_keyboard_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (rst_n),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .scan_code   (scan_code),
        .key_released(key_released),
        .key_extended(key_extended),
        .key_valid   (key_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed pulse activity
    int cyc       = 0;
    int last_fall = 0;
    int kv_cnt    = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int max_lat   = 0;

    // Reference model state
    int         exp_kv   = 0;
    int         exp_err  = 0;
    logic [7:0] exp_code = 8'h00;
    logic       exp_rel  = 1'b0;
    logic       exp_ext  = 1'b0;
    logic       m_ext    = 1'b0;
    logic       m_brk    = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt++;
            if (cyc - last_fall > max_lat) max_lat = cyc - last_fall;
        end
        if (frame_err) err_cnt++;
        if (key_valid && frame_err) both_cnt++;
    end

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par,
                             input logic bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_dat = 1'b1;
    endtask

    // Frame-level model of prefix folding and error handling
    task automatic model_frame(input logic [7:0] b, input logic ok);
        if (!ok) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_code = b;
            exp_rel  = m_brk;
            exp_ext  = m_ext;
            exp_kv++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bits(b, bad_par, bad_stop, 11);
        model_frame(b, !(bad_par || bad_stop));
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if ({scan_code, key_released, key_extended, key_valid, frame_err} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got %h_%b%b%b%b, expected 00_0000",
                     scan_code, key_released, key_extended, key_valid, frame_err);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt + err_cnt !== 0) begin
            fails++;
            $display("FAIL reset_no_pulses: got %0d pulses, expected 0", kv_cnt + err_cnt);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_make;
        frame(8'h1C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || err_cnt !== exp_err) begin
            fails++;
            $display("FAIL make_pulses: got kv=%0d err=%0d, expected kv=%0d err=%0d",
                     kv_cnt, err_cnt, exp_kv, exp_err);
        end
        tests++;
        if ({scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
            fails++;
            $display("FAIL make_outputs: got %h/%b/%b, expected %h/%b/%b",
                     scan_code, key_released, key_extended, exp_code, exp_rel, exp_ext);
        end
        $display("[TB] test_single_make: code=%h rel=%b ext=%b", scan_code, key_released, key_extended);
    endtask

    task automatic test_break;
        int kv0;
        kv0 = kv_cnt;
        frame(8'hF0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== kv0) begin
            fails++;
            $display("FAIL break_prefix_silent: got %0d events, expected 0", kv_cnt - kv0);
        end
        frame(8'h1C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || err_cnt !== exp_err) begin
            fails++;
            $display("FAIL break_pulses: got kv=%0d err=%0d, expected kv=%0d err=%0d",
                     kv_cnt, err_cnt, exp_kv, exp_err);
        end
        tests++;
        if ({scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
            fails++;
            $display("FAIL break_outputs: got %h/%b/%b, expected %h/%b/%b",
                     scan_code, key_released, key_extended, exp_code, exp_rel, exp_ext);
        end
        $display("[TB] test_break: code=%h rel=%b ext=%b", scan_code, key_released, key_extended);
    endtask

    task automatic test_extended;
        frame(8'hE0, 1'b0, 1'b0);
        frame(8'hF0, 1'b0, 1'b0);
        frame(8'h75, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || {scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
            fails++;
            $display("FAIL ext_break: got kv=%0d %h/%b/%b, expected kv=%0d %h/%b/%b",
                     kv_cnt, scan_code, key_released, key_extended, exp_kv, exp_code, exp_rel, exp_ext);
        end
        frame(8'h29, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || {scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
            fails++;
            $display("FAIL ext_flags_cleared: got kv=%0d %h/%b/%b, expected kv=%0d %h/%b/%b",
                     kv_cnt, scan_code, key_released, key_extended, exp_kv, exp_code, exp_rel, exp_ext);
        end
        $display("[TB] test_extended: code=%h rel=%b ext=%b", scan_code, key_released, key_extended);
    endtask

    task automatic test_parity_error;
        frame(8'h1C, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || err_cnt !== exp_err) begin
            fails++;
            $display("FAIL parity_pulses: got kv=%0d err=%0d, expected kv=%0d err=%0d",
                     kv_cnt, err_cnt, exp_kv, exp_err);
        end
        tests++;
        if ({scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
            fails++;
            $display("FAIL parity_outputs_held: got %h/%b/%b, expected %h/%b/%b",
                     scan_code, key_released, key_extended, exp_code, exp_rel, exp_ext);
        end
        frame(8'h29, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || scan_code !== exp_code) begin
            fails++;
            $display("FAIL parity_recover: got kv=%0d code=%h, expected kv=%0d code=%h",
                     kv_cnt, scan_code, exp_kv, exp_code);
        end
        $display("[TB] test_parity_error: err_cnt=%0d code=%h", err_cnt, scan_code);
    endtask

    task automatic test_timeout;
        send_bits(8'h5A, 1'b0, 1'b0, 5);
        repeat (TIMEOUT + 10) @(negedge clk);
        model_frame(8'h00, 1'b0);
        tests++;
        if (err_cnt !== exp_err || kv_cnt !== exp_kv) begin
            fails++;
            $display("FAIL timeout_pulses: got kv=%0d err=%0d, expected kv=%0d err=%0d",
                     kv_cnt, err_cnt, exp_kv, exp_err);
        end
        frame(8'h5A, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || {scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
            fails++;
            $display("FAIL timeout_recover: got kv=%0d %h/%b/%b, expected kv=%0d %h/%b/%b",
                     kv_cnt, scan_code, key_released, key_extended, exp_kv, exp_code, exp_rel, exp_ext);
        end
        $display("[TB] test_timeout: err_cnt=%0d code=%h", err_cnt, scan_code);
    endtask

    task automatic test_reset_glitch;
        send_bits(8'hFF, 1'b0, 1'b0, 6);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if ({scan_code, key_released, key_extended, key_valid, frame_err} !== 12'h000) begin
            fails++;
            $display("FAIL midframe_reset_outputs: got %h_%b%b%b%b, expected 00_0000",
                     scan_code, key_released, key_extended, key_valid, frame_err);
        end
        rst_n    = 1'b1;
        exp_code = 8'h00;
        exp_rel  = 1'b0;
        exp_ext  = 1'b0;
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        ps2_dat  = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        ps2_dat = 1'b1;
        tests++;
        if (kv_cnt !== exp_kv || err_cnt !== exp_err) begin
            fails++;
            $display("FAIL reset_glitch_pulses: got kv=%0d err=%0d, expected kv=%0d err=%0d",
                     kv_cnt, err_cnt, exp_kv, exp_err);
        end
        frame(8'h1C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests++;
        if (kv_cnt !== exp_kv || err_cnt !== exp_err ||
            {scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
            fails++;
            $display("FAIL glitch_then_frame: got kv=%0d err=%0d %h/%b/%b, expected kv=%0d err=%0d %h/%b/%b",
                     kv_cnt, err_cnt, scan_code, key_released, key_extended,
                     exp_kv, exp_err, exp_code, exp_rel, exp_ext);
        end
        $display("[TB] test_reset_glitch: code=%h", scan_code);
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic       bp, bs;
        int         sel;
        for (int n = 0; n < 3; n++) begin
            sel = int'($urandom_range(0, 3));
            b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
            bp  = ($urandom_range(0, 5) == 0);
            bs  = ($urandom_range(0, 7) == 0);
            frame(b, bp, bs);
            repeat (20) @(negedge clk);
            tests++;
            if (kv_cnt !== exp_kv || err_cnt !== exp_err ||
                {scan_code, key_released, key_extended} !== {exp_code, exp_rel, exp_ext}) begin
                fails++;
                $display("FAIL random_frame_%0d: byte=%h got kv=%0d err=%0d %h/%b/%b, expected kv=%0d err=%0d %h/%b/%b",
                         n, b, kv_cnt, err_cnt, scan_code, key_released, key_extended,
                         exp_kv, exp_err, exp_code, exp_rel, exp_ext);
            end
            $display("[TB] random frame %0d: byte=%h badpar=%b badstop=%b code=%h", n, b, bp, bs, scan_code);
        end
    endtask

    task automatic test_ordering;
        tests++;
        if (both_cnt !== 0) begin
            fails++;
            $display("FAIL valid_err_overlap: got %0d overlapping cycles, expected 0", both_cnt);
        end
        tests++;
        if (max_lat > FILTER_LEN + 4 || max_lat < 1) begin
            fails++;
            $display("FAIL event_latency: got %0d cycles, expected 1..%0d", max_lat, FILTER_LEN + 4);
        end
        $display("[TB] test_ordering: max latency %0d cycles", max_lat);
    endtask

    initial begin
        test_reset;
        test_single_make;
        test_break;
        test_extended;
        test_parity_error;
        test_timeout;
        test_reset_glitch;
        test_random;
        test_ordering;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
